// File: rtl/gcd_run_ctrl_if.sv
// Control/status bundle between the APB register file, the run sequencer and the GCD core.
// The sequencer sits on the slave side; the register file and core side is the master.
interface gcd_run_ctrl_if;
    logic        CLK_EN;
    logic        CONSTANT_TIME;
    logic        DEBUG_MODE;
    logic [11:0] OPCODE;
    logic        START_PULSE;
    logic        CORE_DONE;
    logic        CORE_START;
    logic [11:0] CORE_OPCODE;
    logic        CORE_CT;
    logic        CORE_DEBUG;
    logic        START_OUT;
    logic        DONE_PULSE;
    logic [11:0] CYCLE_COUNT;
    logic        TIMEOUT;
    logic        CT_OVERRUN;

    modport master (
        output CLK_EN, CONSTANT_TIME, DEBUG_MODE, OPCODE, START_PULSE, CORE_DONE,
        input  CORE_START, CORE_OPCODE, CORE_CT, CORE_DEBUG, START_OUT, DONE_PULSE,
               CYCLE_COUNT, TIMEOUT, CT_OVERRUN
    );

    modport slave (
        input  CLK_EN, CONSTANT_TIME, DEBUG_MODE, OPCODE, START_PULSE, CORE_DONE,
        output CORE_START, CORE_OPCODE, CORE_CT, CORE_DEBUG, START_OUT, DONE_PULSE,
               CYCLE_COUNT, TIMEOUT, CT_OVERRUN
    );
endinterface

// File: rtl/gcd_run_ctrl.sv
// Run sequencer: latches a start request, launches the GCD core, counts run cycles and
// optionally pads constant-time runs to a fixed length before signalling completion.
module gcd_run_ctrl #(
    parameter logic [11:0] CT_CYCLES      = 12'd1024,
    parameter logic [11:0] TIMEOUT_CYCLES = 12'd4095
) (
    input logic           CLK,
    input logic           RESETn,
    gcd_run_ctrl_if.slave bus
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLaunch = 3'd1;
    localparam logic [2:0] StRun    = 3'd2;
    localparam logic [2:0] StPad    = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [11:0] opcode_q, opcode_d;
    logic [11:0] count_q, count_d;
    logic        ct_q, ct_d;
    logic        debug_q, debug_d;
    logic        timeout_q, timeout_d;
    logic        overrun_q, overrun_d;
    logic [11:0] cnt_next;

    assign cnt_next = count_q + 12'd1;

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        count_d   = count_q;
        ct_d      = ct_q;
        debug_d   = debug_q;
        timeout_d = timeout_q;
        overrun_d = overrun_q;
        case (state_q)
            StIdle: begin
                if (bus.START_PULSE && bus.CLK_EN) begin
                    opcode_d  = bus.OPCODE;
                    ct_d      = bus.CONSTANT_TIME;
                    debug_d   = bus.DEBUG_MODE;
                    count_d   = 12'd0;
                    timeout_d = 1'b0;
                    overrun_d = 1'b0;
                    state_d   = StLaunch;
                end
            end
            StLaunch: state_d = StRun;
            StRun: begin
                // CORE_DONE only counts on enabled cycles; it outranks the timeout check.
                if (bus.CLK_EN) begin
                    count_d = cnt_next;
                    if (bus.CORE_DONE) begin
                        if (!ct_q || (cnt_next >= CT_CYCLES)) begin
                            state_d = StDone;
                            if (ct_q && (cnt_next > CT_CYCLES)) begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            state_d = StPad;
                        end
                    end else if (cnt_next == TIMEOUT_CYCLES) begin
                        timeout_d = 1'b1;
                        state_d   = StDone;
                    end
                end
            end
            StPad: begin
                if (bus.CLK_EN) begin
                    count_d = cnt_next;
                    if (cnt_next == CT_CYCLES) begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= StIdle;
            opcode_q  <= 12'd0;
            count_q   <= 12'd0;
            ct_q      <= 1'b0;
            debug_q   <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            count_q   <= count_d;
            ct_q      <= ct_d;
            debug_q   <= debug_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.CORE_START  = (state_q == StLaunch);
    assign bus.DONE_PULSE  = (state_q == StDone);
    assign bus.START_OUT   = (state_q != StIdle);
    assign bus.CORE_OPCODE = opcode_q;
    assign bus.CORE_CT     = ct_q;
    assign bus.CORE_DEBUG  = debug_q;
    assign bus.CYCLE_COUNT = count_q;
    assign bus.TIMEOUT     = timeout_q;
    assign bus.CT_OVERRUN  = overrun_q;

endmodule

// File: tb/tb_gcd_run_ctrl.sv
// Scoreboard bench for gcd_run_ctrl: the driver predicts each run's outcome from the
// run-length rules and queues it; a monitor pops and compares on every DONE_PULSE.
module tb_gcd_run_ctrl;

    localparam logic [11:0] CT  = 12'd16;
    localparam logic [11:0] TMO = 12'd32;

    typedef struct {
        logic [11:0] op;
        logic        ct;
        logic        dbg;
        logic [11:0] count;
        logic        to;
        logic        ov;
    } exp_t;

    logic CLK;
    logic RESETn;
    int   total;
    int   bad;
    int   last_count;
    exp_t sb[$];

    gcd_run_ctrl_if bus ();

    gcd_run_ctrl #(
        .CT_CYCLES      (CT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outcome from the run rules: D enabled RUN cycles until the core reports done.
    function automatic exp_t predict(input logic [11:0] op, input logic ct, input logic dbg,
                                     input int d);
        exp_t e;
        e.op  = op;
        e.ct  = ct;
        e.dbg = dbg;
        e.to  = 1'b0;
        e.ov  = 1'b0;
        if (d >= int'(TMO) + 1) begin
            e.count = TMO;
            e.to    = 1'b1;
        end else begin
            e.count = (ct && d < int'(CT)) ? CT : 12'(d);
            e.ov    = ct && (d > int'(CT));
        end
        return e;
    endfunction

    task automatic do_run(input logic [11:0] op, input logic ct, input logic dbg, input int d,
                          input int en_pct, input bit abort_pad);
        exp_t e;
        int   n;
        int   k;
        int   limit;
        logic en;
        e = predict(op, ct, dbg, d);
        if (!abort_pad) sb.push_back(e);
        @(negedge CLK);
        bus.START_PULSE   = 1'b1;
        bus.CLK_EN        = 1'b1;
        bus.OPCODE        = op;
        bus.CONSTANT_TIME = ct;
        bus.DEBUG_MODE    = dbg;
        bus.CORE_DONE     = 1'b0;
        @(negedge CLK);
        bus.START_PULSE   = 1'b0;
        bus.OPCODE        = 12'($urandom);
        bus.CONSTANT_TIME = 1'($urandom);
        bus.DEBUG_MODE    = 1'($urandom);
        check("launch_strobe", 32'(bus.CORE_START), 32'd1);
        check("launch_busy", 32'(bus.START_OUT), 32'd1);
        check("launch_clear", {bus.CYCLE_COUNT, bus.TIMEOUT, bus.CT_OVERRUN}, 32'd0);
        check("launch_latch", {bus.CORE_OPCODE, bus.CORE_CT, bus.CORE_DEBUG}, {op, ct, dbg});
        @(negedge CLK);
        check("launch_once", 32'(bus.CORE_START), 32'd0);
        limit = (d < int'(TMO)) ? d : int'(TMO);
        n = 0;
        while (n < limit) begin
            en = ($urandom_range(99) < en_pct);
            if (en) n++;
            bus.CLK_EN      = en;
            bus.CORE_DONE   = en ? (n == d) : 1'($urandom);
            bus.START_PULSE = ($urandom_range(7) == 0);
            bus.OPCODE      = 12'($urandom);
            @(negedge CLK);
        end
        bus.START_PULSE = 1'b0;
        if (abort_pad) begin
            for (int i = 0; i < 3; i++) begin
                bus.CLK_EN    = 1'b1;
                bus.CORE_DONE = 1'($urandom);
                @(negedge CLK);
            end
            RESETn = 1'b0;
            #1;
            check("rst_flags", {bus.START_OUT, bus.CORE_START, bus.DONE_PULSE, bus.TIMEOUT,
                                bus.CT_OVERRUN, bus.CORE_CT, bus.CORE_DEBUG}, 32'd0);
            check("rst_count", {bus.CYCLE_COUNT, bus.CORE_OPCODE}, 32'd0);
            @(negedge CLK);
            @(negedge CLK);
            RESETn        = 1'b1;
            bus.CORE_DONE = 1'b0;
            last_count    = 0;
            repeat (20) @(negedge CLK);
            check("rst_idle", 32'(bus.START_OUT), 32'd0);
        end else begin
            k = 0;
            while (!bus.DONE_PULSE && k < 200) begin
                bus.CLK_EN    = ($urandom_range(99) < en_pct);
                bus.CORE_DONE = ($urandom_range(2) == 0);
                @(negedge CLK);
                k++;
            end
            check("done_seen", 32'(bus.DONE_PULSE), 32'd1);
            bus.CORE_DONE = 1'b0;
            bus.CLK_EN    = 1'b1;
            last_count    = int'(e.count);
        end
    endtask

    // Monitor: every DONE_PULSE must match the oldest outstanding prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RESETn && bus.DONE_PULSE) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_opcode", 32'(bus.CORE_OPCODE), 32'(e.op));
                    check("done_ct_dbg", {bus.CORE_CT, bus.CORE_DEBUG}, {e.ct, e.dbg});
                    check("done_count", 32'(bus.CYCLE_COUNT), 32'(e.count));
                    check("done_timeout", 32'(bus.TIMEOUT), 32'(e.to));
                    check("done_overrun", 32'(bus.CT_OVERRUN), 32'(e.ov));
                    check("done_busy", {bus.START_OUT, bus.CORE_START}, 32'b10);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total             = 0;
        bad               = 0;
        last_count        = 0;
        RESETn            = 1'b0;
        bus.CLK_EN        = 1'b0;
        bus.CONSTANT_TIME = 1'b0;
        bus.DEBUG_MODE    = 1'b0;
        bus.OPCODE        = 12'd0;
        bus.START_PULSE   = 1'b0;
        bus.CORE_DONE     = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_outs", {bus.START_OUT, bus.CORE_START, bus.DONE_PULSE, bus.TIMEOUT,
                             bus.CT_OVERRUN, bus.CORE_CT, bus.CORE_DEBUG}, 32'd0);
        check("reset_regs", {bus.CYCLE_COUNT, bus.CORE_OPCODE}, 32'd0);
        RESETn = 1'b1;

        do_run(12'h0A5, 1'b0, 1'b0, 5, 100, 1'b0);   // basic
        do_run(12'h123, 1'b1, 1'b0, 6, 100, 1'b0);   // padded to CT
        do_run(12'h456, 1'b1, 1'b1, 20, 100, 1'b0);  // overrun, no pad
        do_run(12'h789, 1'b0, 1'b0, 1000, 100, 1'b0);// timeout
        do_run(12'h0F0, 1'b0, 1'b1, 3, 100, 1'b0);   // start clears TIMEOUT

        // A start with CLK_EN low is dropped and the last count is retained.
        @(negedge CLK);
        bus.START_PULSE = 1'b1;
        bus.CLK_EN      = 1'b0;
        @(negedge CLK);
        bus.START_PULSE = 1'b0;
        bus.CLK_EN      = 1'b1;
        check("drop_busy", {bus.START_OUT, bus.CORE_START}, 32'd0);
        check("drop_count", 32'(bus.CYCLE_COUNT), 32'(last_count));

        do_run(12'hABC, 1'b0, 1'b0, 5, 50, 1'b0);    // gated RUN
        do_run(12'hDEF, 1'b1, 1'b0, 10, 50, 1'b0);  // gated RUN and PAD
        do_run(12'h321, 1'b1, 1'b0, 6, 100, 1'b1);   // reset mid-PAD
        check("post_rst_count", 32'(bus.CYCLE_COUNT), 32'd0);
        do_run(12'h654, 1'b0, 1'b0, 4, 100, 1'b0);   // fresh start after reset

        for (int i = 0; i < 40; i++) begin
            do_run(12'($urandom), 1'($urandom), 1'($urandom), $urandom_range(1, 40),
                   $urandom_range(40, 100), 1'b0);
        end

        repeat (5) @(negedge CLK);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
